// File: rtl/max_pool_pkg.sv
// rtl/max_pool_pkg.sv - shared types, constants and signed max helper for the max-pool stages
package max_pool_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mp_state_t;

    localparam logic [31:0] MP_ADDR_STRIDE = 32'd4;
    localparam logic [3:0]  MP_WE_ALL      = 4'hF;

    // Callers sign-extend narrower pixels to 32 bits before comparing.
    function automatic logic signed [31:0] mp_smax(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_2_line_buf.sv
// rtl/max_pool_2_line_buf.sv - half-row line buffer, combinational read / synchronous write
module max_pool_2_line_buf #(
    parameter int DEPTH  = 14,
    parameter int DATA_W = 16,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents are never reset: every entry is written on an even row before the odd row reads it.
    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read keeps the odd-row compare in the same cycle as the pixel.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/max_pool_2_stream_writer.sv
// rtl/max_pool_2_stream_writer.sv - streaming 2x2/stride-2 max-pool writing pooled words to BRAM port A
module max_pool_2_stream_writer
    import max_pool_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter int          IMG_W     = 28,
    parameter int          IMG_H     = 28,
    parameter int          CHANNELS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    output logic [31:0]              bram_addr,
    output logic [31:0]              bram_din,
    output logic                     bram_en,
    output logic [3:0]               bram_we,
    output logic                     busy,
    output logic                     done
);

    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int CW       = $clog2(IMG_W);
    localparam int RW       = $clog2(IMG_H);
    localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CHW-1:0] CH_LAST  = CHW'(CHANNELS - 1);
    localparam bit             W_ODD    = (IMG_W % 2) == 1;
    localparam bit             H_ODD    = (IMG_H % 2) == 1;

    mp_state_t                 state_q, state_d;
    logic [CW-1:0]             col_q, col_d;
    logic [RW-1:0]             row_q, row_d;
    logic [CHW-1:0]            ch_q, ch_d;
    logic [31:0]               k_q, k_d;
    logic signed [DATA_W-1:0]  h_q, h_d;
    logic [31:0]               bram_addr_q, bram_addr_d;
    logic [31:0]               bram_din_q, bram_din_d;
    logic                      bram_en_q, bram_en_d;

    logic                      accept;
    logic                      in_window;
    logic                      lb_we;
    logic [LB_AW-1:0]          lb_addr;
    logic signed [DATA_W-1:0]  lb_wdata;
    logic signed [DATA_W-1:0]  lb_rdata;
    logic signed [31:0]        max_hx;
    logic signed [31:0]        max_lx;

    max_pool_2_line_buf #(
        .DEPTH  (LB_DEPTH),
        .DATA_W (DATA_W),
        .AW     (LB_AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (lb_wdata),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    // Window position decode, pooling datapath and frame sequencing.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        ch_d        = ch_q;
        k_d         = k_q;
        h_d         = h_q;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        bram_en_d   = 1'b0;
        lb_we       = 1'b0;

        accept    = (state_q == RUN) && s_valid;
        // Trailing odd column/row pixels are swallowed without touching the datapath.
        in_window = !(W_ODD && (col_q == COL_LAST)) && !(H_ODD && (row_q == ROW_LAST));
        lb_addr   = LB_AW'(col_q >> 1);
        max_hx    = mp_smax(32'(h_q), 32'(s_data));
        max_lx    = mp_smax(32'(lb_rdata), 32'(s_data));
        lb_wdata  = DATA_W'(max_hx);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                    ch_d    = '0;
                    k_d     = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (in_window) begin
                        case ({row_q[0], col_q[0]})
                            2'b00: h_d = s_data;
                            2'b01: lb_we = 1'b1;
                            2'b10: h_d = DATA_W'(max_lx);
                            default: begin
                                bram_en_d   = 1'b1;
                                bram_addr_d = BASE_ADDR + k_q * MP_ADDR_STRIDE;
                                bram_din_d  = max_hx;
                                k_d         = k_q + 32'd1;
                            end
                        endcase
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d = '0;
                            if (ch_q == CH_LAST) begin
                                ch_d    = '0;
                                state_d = DONE;
                            end else begin
                                ch_d = ch_q + 1'b1;
                            end
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered BRAM port; asynchronous reset returns everything to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            ch_q        <= '0;
            k_q         <= '0;
            h_q         <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            bram_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            k_q         <= k_d;
            h_q         <= h_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            bram_en_q   <= bram_en_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        s_ready   = (state_q == RUN);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        bram_addr = bram_addr_q;
        bram_din  = bram_din_q;
        bram_en   = bram_en_q;
        bram_we   = bram_en_q ? MP_WE_ALL : 4'h0;
    end

endmodule

// File: tb/tb_max_pool_2_stream_writer.sv
// tb/tb_max_pool_2_stream_writer.sv - directed self-checking bench for max_pool_2_stream_writer
module tb_max_pool_2_stream_writer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  we;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic signed [15:0] s_data = '0;
    logic start4 = 1'b0, start5 = 1'b0, start2 = 1'b0;

    logic        rdy4, en4, busy4, done4;
    logic [31:0] addr4, din4;
    logic [3:0]  we4;
    logic        rdy5, en5, busy5, done5;
    logic [31:0] addr5, din5;
    logic [3:0]  we5;
    logic        rdy2, en2, busy2, done2;
    logic [31:0] addr2, din2;
    logic [3:0]  we2;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt4 = 0;
    int pix [64];
    wr_t q4[$], q5[$], q2[$];

    always #5 clk = ~clk;

    max_pool_2_stream_writer #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .CHANNELS(1), .BASE_ADDR(32'h0)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .s_valid(s_valid), .s_ready(rdy4), .s_data(s_data),
        .bram_addr(addr4), .bram_din(din4), .bram_en(en4), .bram_we(we4), .busy(busy4), .done(done4));

    max_pool_2_stream_writer #(.DATA_W(16), .IMG_W(5), .IMG_H(5), .CHANNELS(1), .BASE_ADDR(32'h0)) u5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .s_valid(s_valid), .s_ready(rdy5), .s_data(s_data),
        .bram_addr(addr5), .bram_din(din5), .bram_en(en5), .bram_we(we5), .busy(busy5), .done(done5));

    max_pool_2_stream_writer #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .CHANNELS(2), .BASE_ADDR(32'h0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .s_valid(s_valid), .s_ready(rdy2), .s_data(s_data),
        .bram_addr(addr2), .bram_din(din2), .bram_en(en2), .bram_we(we2), .busy(busy2), .done(done2));

    always @(negedge clk) begin
        if (en4 === 1'b1) q4.push_back('{addr4, din4, we4});
        if (en5 === 1'b1) q5.push_back('{addr5, din5, we5});
        if (en2 === 1'b1) q2.push_back('{addr2, din2, we2});
        if (done4 === 1'b1) done_cnt4++;
    end

    function automatic logic rdy_of(input int sel);
        case (sel)
            0: return rdy4;
            1: return rdy5;
            default: return rdy2;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: start4 = v;
            1: start5 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic pulse_start(input int sel);
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
    endtask

    // Streams pix[0..n-1]; s_ready is checked on every presented pixel.
    task automatic send_pixels(input int sel, input int n, input bit stalls, input int start_at);
        for (int i = 0; i < n; i++) begin
            if (stalls && ($urandom_range(0, 1) == 1)) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = 16'(pix[i]);
            if (i == start_at) set_start(sel, 1'b1);
            n_cmp++;
            if (rdy_of(sel) !== 1'b1) begin
                n_fail++;
                $display("FAIL s_ready_pixel%0d sel%0d: got %b want 1", i, sel, rdy_of(sel));
            end
            @(posedge clk); #1;
            set_start(sel, 1'b0);
        end
        s_valid = 1'b0;
    endtask

    task automatic load_ramp(input int n);
        for (int i = 0; i < n; i++) pix[i] = i;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (rdy4 !== 1'b0)   begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", rdy4); end
        n_cmp++; if (addr4 !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr4); end
        n_cmp++; if (din4 !== 32'h0)  begin n_fail++; $display("FAIL reset_din: got %h want 0", din4); end
        n_cmp++; if (en4 !== 1'b0)    begin n_fail++; $display("FAIL reset_en: got %b want 0", en4); end
        n_cmp++; if (we4 !== 4'h0)    begin n_fail++; $display("FAIL reset_we: got %h want 0", we4); end
        n_cmp++; if (busy4 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy4); end
        n_cmp++; if (done4 !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", done4); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_ramp;
        int exp_v [4] = '{5, 7, 13, 15};
        q4.delete();
        load_ramp(16);
        pulse_start(0);
        n_cmp++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL ramp_busy_after_start: got %b want 1", busy4); end
        send_pixels(0, 16, 1'b0, -1);
        n_cmp++; if (done4 !== 1'b1) begin n_fail++; $display("FAIL ramp_done_cycle: got %b want 1", done4); end
        n_cmp++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL ramp_busy_done_cycle: got %b want 1", busy4); end
        n_cmp++; if (en4 !== 1'b1 || din4 !== 32'd15) begin
            n_fail++; $display("FAIL ramp_final_write: got en=%b din=%0d want en=1 din=15", en4, din4);
        end
        @(posedge clk); #1;
        n_cmp++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            n_fail++; $display("FAIL ramp_idle: got busy=%b done=%b want 0 0", busy4, done4);
        end
        n_cmp++; if (q4.size() != 4) begin n_fail++; $display("FAIL ramp_count: got %0d want 4", q4.size()); end
        for (int i = 0; i < 4 && i < q4.size(); i++) begin
            n_cmp++;
            if (q4[i].addr !== 32'(4 * i) || q4[i].din !== 32'(exp_v[i]) || q4[i].we !== 4'hF) begin
                n_fail++;
                $display("FAIL ramp_write%0d: got addr=%h din=%h we=%h want addr=%h din=%h we=f",
                         i, q4[i].addr, q4[i].din, q4[i].we, 4 * i, exp_v[i]);
            end
        end
    endtask

    task automatic test_negative;
        q4.delete();
        for (int i = 0; i < 16; i++) pix[i] = 0;
        pix[0] = -3; pix[1] = -3; pix[4] = -1; pix[5] = -3;
        pulse_start(0);
        send_pixels(0, 16, 1'b0, -1);
        @(posedge clk); #1;
        n_cmp++; if (q4.size() != 4) begin n_fail++; $display("FAIL neg_count: got %0d want 4", q4.size()); end
        if (q4.size() > 0) begin
            n_cmp++;
            if (q4[0].din !== 32'hFFFF_FFFF || q4[0].we !== 4'hF || q4[0].addr !== 32'h0) begin
                n_fail++;
                $display("FAIL neg_write: got addr=%h din=%h we=%h want addr=0 din=ffffffff we=f",
                         q4[0].addr, q4[0].din, q4[0].we);
            end
        end
    endtask

    task automatic test_odd_dims;
        int exp_v [4] = '{6, 8, 16, 18};
        q5.delete();
        load_ramp(25);
        pulse_start(1);
        send_pixels(1, 25, 1'b0, -1);
        n_cmp++; if (done5 !== 1'b1 || en5 !== 1'b0) begin
            n_fail++; $display("FAIL odd_done_cycle: got done=%b en=%b want 1 0", done5, en5);
        end
        @(posedge clk); #1;
        n_cmp++; if (q5.size() != 4) begin n_fail++; $display("FAIL odd_count: got %0d want 4", q5.size()); end
        for (int i = 0; i < 4 && i < q5.size(); i++) begin
            n_cmp++;
            if (q5[i].addr !== 32'(4 * i) || q5[i].din !== 32'(exp_v[i])) begin
                n_fail++;
                $display("FAIL odd_write%0d: got addr=%h din=%0d want addr=%h din=%0d",
                         i, q5[i].addr, q5[i].din, 4 * i, exp_v[i]);
            end
        end
    endtask

    task automatic test_multi_channel_stalls;
        int exp_v [8] = '{5, 7, 13, 15, 21, 23, 29, 31};
        q2.delete();
        load_ramp(32);
        pulse_start(2);
        send_pixels(2, 32, 1'b1, -1);
        n_cmp++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL mc_done: got %b want 1", done2); end
        @(posedge clk); #1;
        n_cmp++; if (q2.size() != 8) begin n_fail++; $display("FAIL mc_count: got %0d want 8", q2.size()); end
        for (int i = 0; i < 8 && i < q2.size(); i++) begin
            n_cmp++;
            if (q2[i].addr !== 32'(4 * i) || q2[i].din !== 32'(exp_v[i]) || q2[i].we !== 4'hF) begin
                n_fail++;
                $display("FAIL mc_write%0d: got addr=%h din=%0d we=%h want addr=%h din=%0d we=f",
                         i, q2[i].addr, q2[i].din, q2[i].we, 4 * i, exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int exp_v [4] = '{5, 7, 13, 15};
        load_ramp(16);
        pulse_start(0);
        send_pixels(0, 7, 1'b0, -1);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (din4 !== 32'h0 || addr4 !== 32'h0) begin
            n_fail++; $display("FAIL midrst_addr_din: got addr=%h din=%h want 0 0", addr4, din4);
        end
        n_cmp++; if (rdy4 !== 1'b0 || busy4 !== 1'b0 || en4 !== 1'b0 || we4 !== 4'h0 || done4 !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ctrl: got rdy=%b busy=%b en=%b we=%h done=%b want all 0",
                               rdy4, busy4, en4, we4, done4);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        q4.delete();
        pulse_start(0);
        send_pixels(0, 16, 1'b0, -1);
        @(posedge clk); #1;
        n_cmp++; if (q4.size() != 4) begin n_fail++; $display("FAIL midrst_count: got %0d want 4", q4.size()); end
        for (int i = 0; i < 4 && i < q4.size(); i++) begin
            n_cmp++;
            if (q4[i].addr !== 32'(4 * i) || q4[i].din !== 32'(exp_v[i])) begin
                n_fail++;
                $display("FAIL midrst_write%0d: got addr=%h din=%0d want addr=%h din=%0d",
                         i, q4[i].addr, q4[i].din, 4 * i, exp_v[i]);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int exp_v [4] = '{5, 7, 13, 15};
        int d0;
        q4.delete();
        load_ramp(16);
        d0 = done_cnt4;
        pulse_start(0);
        send_pixels(0, 16, 1'b0, 5);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (done_cnt4 - d0 != 1) begin n_fail++; $display("FAIL swb_done_count: got %0d want 1", done_cnt4 - d0); end
        n_cmp++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL swb_idle: got busy=%b want 0", busy4); end
        n_cmp++; if (q4.size() != 4) begin n_fail++; $display("FAIL swb_count: got %0d want 4", q4.size()); end
        for (int i = 0; i < 4 && i < q4.size(); i++) begin
            n_cmp++;
            if (q4[i].addr !== 32'(4 * i) || q4[i].din !== 32'(exp_v[i])) begin
                n_fail++;
                $display("FAIL swb_write%0d: got addr=%h din=%0d want addr=%h din=%0d",
                         i, q4[i].addr, q4[i].din, 4 * i, exp_v[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_ramp();
        test_negative();
        test_odd_dims();
        test_multi_channel_stalls();
        test_reset_mid_frame();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
